// File: rtl/stream_input_player_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_input_player_if
// Description : Host-side event handshake for stream_input_player. The host
//               offers (delay, value) pairs with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_input_player_if #(
    parameter int DATA_W  = 64,
    parameter int DELAY_W = 32
);
    logic                      s_valid;
    logic                      s_ready;
    logic        [DELAY_W-1:0] s_delay;
    logic signed [DATA_W-1:0]  s_value;

    // Host side: offers events
    modport master (
        output s_valid,
        output s_delay,
        output s_value,
        input  s_ready
    );

    // Player side: accepts events
    modport slave (
        input  s_valid,
        input  s_delay,
        input  s_value,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/stream_input_player.sv
`default_nettype none
// ============================================================================
// Module      : stream_input_player
// Description : Replays queued (delay, value) events into a monitor input
//               port as single-cycle strobes at their scheduled times.
//               Optional macro STREAM_PLAYER_LATE_CNT_EN builds the lateness
//               detector and the saturating late_cnt register; otherwise
//               late_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_input_player #(
    parameter int DATA_W  = 64,
    parameter int DELAY_W = 32,
    parameter int DEPTH   = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,      // asynchronous, active-low
    input  wire logic                     en,
    stream_input_player_if.slave          s_if,
    output logic signed [DATA_W-1:0]      input_0,
    output logic                          new_input_0,
    output logic                          busy,
    output logic        [15:0]            late_cnt
);

    localparam int                 c_aw        = $clog2(DEPTH);
    localparam logic [c_aw:0]      c_ptr_one   = {{c_aw{1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] c_dly_one   = {{(DELAY_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    // Event storage (no reset needed: validity is tracked by the pointers)
    logic        [DELAY_W-1:0] r_mem_delay [DEPTH];
    logic signed [DATA_W-1:0]  r_mem_value [DEPTH];

    logic [c_aw:0]             r_wr;
    logic [c_aw:0]             r_rd;
    state_t                    r_state;
    state_t                    w_state_nx;
    logic [DELAY_W-1:0]        r_elapsed;     // enabled cycles since last pulse
    logic                      r_pulse;
    logic signed [DATA_W-1:0]  r_value;

    logic [c_aw:0]             w_count;
    logic                      w_full;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_cand_avail;
    logic [c_aw-1:0]           w_cand_idx;
    logic [DELAY_W-1:0]        w_cand_delay;
    logic [DELAY_W-1:0]        w_dly_eff;
    logic [DELAY_W-1:0]        w_since;
    logic [DELAY_W-1:0]        w_since_nx;
    logic                      w_fire;

    assign w_count     = r_wr - r_rd;
    assign w_full      = (r_wr[c_aw] != r_rd[c_aw]) && (r_wr[c_aw-1:0] == r_rd[c_aw-1:0]);
    assign s_if.s_ready = !w_full && en;
    assign w_push      = s_if.s_valid && !w_full && en;
    // The entry on show is retired at the end of the cycle its strobe is visible
    assign w_pop       = r_pulse && en;

    // Scheduling decision for the next cycle's strobe. While a strobe is on
    // show, the head is already committed, so the candidate is the entry
    // behind it and the time since the last pulse restarts from zero.
    always_comb begin
        w_cand_avail = r_pulse ? (w_count > c_ptr_one) : (r_state == ST_ARMED);
        w_cand_idx   = r_rd[c_aw-1:0] + c_aw'(r_pulse);
        w_cand_delay = r_mem_delay[w_cand_idx];
        w_dly_eff    = (w_cand_delay == '0) ? c_dly_one : w_cand_delay;
        w_since      = r_pulse ? '0 : r_elapsed;
        w_since_nx   = (&w_since) ? w_since : (w_since + c_dly_one);
        w_fire       = en && w_cand_avail && (w_since_nx >= w_dly_eff);
    end

    // FIFO write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_delay[r_wr[c_aw-1:0]] <= s_if.s_delay;
            r_mem_value[r_wr[c_aw-1:0]] <= s_if.s_value;
        end
    end

    // Pointers, elapsed counter and registered strobe; all frozen while en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_elapsed <= '0;
            r_pulse   <= 1'b0;
            r_value   <= '0;
        end else if (en) begin
            if (w_push) r_wr <= r_wr + c_ptr_one;
            if (w_pop)  r_rd <= r_rd + c_ptr_one;
            r_elapsed <= w_since_nx;
            r_pulse   <= w_fire;
            r_value   <= w_fire ? r_mem_value[w_cand_idx] : '0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else if (en) begin
            r_state <= w_state_nx;
        end
    end

    // Next state: ARMED whenever the FIFO holds at least one entry
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) w_state_nx = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_pop && !w_push && (w_count == c_ptr_one)) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_ARMED);

    // A strobe already registered must not leak out during a disabled cycle;
    // it stays held and appears in the next enabled cycle.
    assign new_input_0 = r_pulse && en;
    assign input_0     = en ? r_value : '0;

`ifdef STREAM_PLAYER_LATE_CNT_EN
    logic        w_late;
    logic [15:0] r_late_cnt;

    // An event firing beyond its nominal delay was held back by its own arrival
    assign w_late = w_fire && (w_since_nx > w_dly_eff);

    // Saturating lateness counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_late_cnt <= '0;
        end else if (en && w_late && (r_late_cnt != 16'hFFFF)) begin
            r_late_cnt <= r_late_cnt + 16'd1;
        end
    end

    assign late_cnt = r_late_cnt;
`else
    assign late_cnt = '0;
`endif

endmodule
`default_nettype wire
